// File: rtl/peak_window_detector_pkg.sv
// Shared types and helpers for the windowed range-bin peak detector.
package peak_window_detector_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_REPORT = 2'd2
    } pd_state_t;

    // Counter width for n states; a single-state counter still needs one bit.
    function automatic int pd_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/peak_window_detector_cmp.sv
// Strict "a beats b" compare: a > b when searching max, a < b when searching min.
module peak_window_detector_cmp #(
    parameter int DATA_W = 32,
    parameter int SIGNED = 0
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              mode_min,
    output logic              a_better
);

    logic a_gt;
    logic b_gt;

    assign a_gt     = (SIGNED != 0) ? ($signed(a) > $signed(b)) : (a > b);
    assign b_gt     = (SIGNED != 0) ? ($signed(b) > $signed(a)) : (b > a);
    assign a_better = mode_min ? b_gt : a_gt;

endmodule

// File: rtl/peak_window_detector.sv
// Splits the sample stream into BIN_LEN-sample bins and reports the windowed extreme of each bin.
//
//  state     | meaning
//  ST_IDLE   | no bin in progress; first enabled sample starts a bin as idx 0
//  ST_RUN    | accumulating a bin; pd_enable low aborts it
//  ST_REPORT | one-cycle result strobe; an enabled sample here starts the next bin
module peak_window_detector
    import peak_window_detector_pkg::*;
#(
    parameter int  DATA_W   = 32,
    parameter int  ADDR_W   = 14,
    parameter int  BIN_LEN  = 1024,
    parameter int  NUM_BINS = 32,
    parameter int  SIGNED   = 0,
    localparam int IDX_W    = pd_width(BIN_LEN),
    localparam int BIN_W    = pd_width(NUM_BINS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pd_enable,
    input  logic              mode_min,
    input  logic [IDX_W-1:0]  win_start,
    input  logic [IDX_W-1:0]  win_end,
    input  logic [DATA_W-1:0] threshold,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    input  logic [ADDR_W-1:0] s_addr,
    output logic              pk_valid,
    output logic [DATA_W-1:0] pk_value,
    output logic [ADDR_W-1:0] pk_addr,
    output logic [IDX_W-1:0]  pk_idx,
    output logic [BIN_W-1:0]  pk_bin,
    output logic              pk_found,
    output logic              busy
);

    pd_state_t state_q, state_d;

    logic              mode_q;
    logic [IDX_W-1:0]  ws_q, we_q;
    logic [DATA_W-1:0] thr_q;
    logic [IDX_W-1:0]  idx_q;
    logic [BIN_W-1:0]  bin_q;
    logic              cand_vld_q;
    logic [DATA_W-1:0] cand_val_q;
    logic [ADDR_W-1:0] cand_addr_q;
    logic [IDX_W-1:0]  cand_idx_q;

    logic              at_start;
    logic              eff_mode;
    logic [IDX_W-1:0]  eff_ws, eff_we;
    logic [DATA_W-1:0] eff_thr;
    logic [IDX_W-1:0]  cur_idx;
    logic              in_win, base_vld, smp_better, take, last;
    logic              nxt_vld;
    logic [DATA_W-1:0] nxt_val;
    logic [ADDR_W-1:0] nxt_addr;
    logic [IDX_W-1:0]  nxt_idx;
    logic              thr_beat;
    logic              latch, step, report_ld;

    // A sample arriving in IDLE or REPORT opens a bin, so it must see the live configuration.
    assign at_start = (state_q != ST_RUN);
    assign eff_mode = at_start ? mode_min  : mode_q;
    assign eff_ws   = at_start ? win_start : ws_q;
    assign eff_we   = at_start ? win_end   : we_q;
    assign eff_thr  = at_start ? threshold : thr_q;
    assign cur_idx  = at_start ? '0 : idx_q;
    assign last     = (cur_idx == IDX_W'(BIN_LEN - 1));

    assign in_win   = (cur_idx >= eff_ws) && (cur_idx <= eff_we);
    assign base_vld = !at_start && cand_vld_q;

    peak_window_detector_cmp #(.DATA_W(DATA_W), .SIGNED(SIGNED)) u_cmp_cand (
        .a        (s_data),
        .b        (cand_val_q),
        .mode_min (eff_mode),
        .a_better (smp_better)
    );

    assign take     = in_win && (!base_vld || smp_better);
    assign nxt_vld  = base_vld || in_win;
    assign nxt_val  = take ? s_data  : cand_val_q;
    assign nxt_addr = take ? s_addr  : cand_addr_q;
    assign nxt_idx  = take ? cur_idx : cand_idx_q;

    peak_window_detector_cmp #(.DATA_W(DATA_W), .SIGNED(SIGNED)) u_cmp_thr (
        .a        (nxt_val),
        .b        (eff_thr),
        .mode_min (eff_mode),
        .a_better (thr_beat)
    );

    always_comb begin
        state_d = state_q;
        latch   = 1'b0;
        step    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pd_enable && s_valid) begin
                    latch   = 1'b1;
                    step    = 1'b1;
                    state_d = last ? ST_REPORT : ST_RUN;
                end
            end
            ST_RUN: begin
                if (!pd_enable) begin
                    state_d = ST_IDLE;
                end else if (s_valid) begin
                    step = 1'b1;
                    if (last) state_d = ST_REPORT;
                end
            end
            ST_REPORT: begin
                if (pd_enable) begin
                    latch   = 1'b1;
                    state_d = ST_RUN;
                    if (s_valid) begin
                        step = 1'b1;
                        if (last) state_d = ST_REPORT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign report_ld = step && last;
    assign busy      = (state_q != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mode_q      <= 1'b0;
            ws_q        <= '0;
            we_q        <= '0;
            thr_q       <= '0;
            idx_q       <= '0;
            bin_q       <= '0;
            cand_vld_q  <= 1'b0;
            cand_val_q  <= '0;
            cand_addr_q <= '0;
            cand_idx_q  <= '0;
            pk_valid    <= 1'b0;
            pk_value    <= '0;
            pk_addr     <= '0;
            pk_idx      <= '0;
            pk_bin      <= '0;
            pk_found    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pk_valid <= report_ld;
            if (latch) begin
                mode_q <= mode_min;
                ws_q   <= win_start;
                we_q   <= win_end;
                thr_q  <= threshold;
            end
            if (step) begin
                idx_q       <= cur_idx + 1'b1;
                cand_vld_q  <= nxt_vld;
                cand_val_q  <= nxt_val;
                cand_addr_q <= nxt_addr;
                cand_idx_q  <= nxt_idx;
            end else if (latch) begin
                idx_q      <= '0;
                cand_vld_q <= 1'b0;
            end
            // Result is formed from the candidate including the final sample, giving one-cycle latency.
            if (report_ld) begin
                pk_value <= nxt_vld ? nxt_val  : '0;
                pk_addr  <= nxt_vld ? nxt_addr : '0;
                pk_idx   <= nxt_vld ? nxt_idx  : '0;
                pk_found <= nxt_vld && thr_beat;
                pk_bin   <= bin_q;
                bin_q    <= (bin_q == BIN_W'(NUM_BINS - 1)) ? '0 : bin_q + 1'b1;
            end else if (state_d == ST_IDLE) begin
                bin_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_peak_window_detector.sv
// Scoreboard bench for peak_window_detector: a reference model pushes each bin's expected result.
`timescale 1ns/1ps
module tb_peak_window_detector;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 14;
    localparam int BIN_LEN  = 1024;
    localparam int NUM_BINS = 2;
    localparam int SIGNED   = 1;
    localparam int IDX_W    = 10;
    localparam int BIN_W    = 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              pd_enable = 1'b0;
    logic              mode_min = 1'b0;
    logic [IDX_W-1:0]  win_start = '0;
    logic [IDX_W-1:0]  win_end = '0;
    logic [DATA_W-1:0] threshold = '0;
    logic              s_valid = 1'b0;
    logic [DATA_W-1:0] s_data = '0;
    logic [ADDR_W-1:0] s_addr = '0;
    logic              pk_valid;
    logic [DATA_W-1:0] pk_value;
    logic [ADDR_W-1:0] pk_addr;
    logic [IDX_W-1:0]  pk_idx;
    logic [BIN_W-1:0]  pk_bin;
    logic              pk_found;
    logic              busy;

    peak_window_detector #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BIN_LEN(BIN_LEN),
        .NUM_BINS(NUM_BINS), .SIGNED(SIGNED)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pd_enable(pd_enable), .mode_min(mode_min),
        .win_start(win_start), .win_end(win_end), .threshold(threshold),
        .s_valid(s_valid), .s_data(s_data), .s_addr(s_addr),
        .pk_valid(pk_valid), .pk_value(pk_value), .pk_addr(pk_addr),
        .pk_idx(pk_idx), .pk_bin(pk_bin), .pk_found(pk_found), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] value;
        logic [ADDR_W-1:0] addr;
        logic [IDX_W-1:0]  idx;
        logic [BIN_W-1:0]  bin;
        logic              found;
        int                cyc;
    } exp_t;

    exp_t              exp_q[$];
    logic [DATA_W-1:0] bin_data[BIN_LEN];
    logic [ADDR_W-1:0] bin_addr[BIN_LEN];
    int                n_checks = 0;
    int                n_fail = 0;
    int                ncyc = 0;
    int                exp_bin = 0;
    logic              cfg_min;
    logic [IDX_W-1:0]  cfg_ws, cfg_we;
    logic [DATA_W-1:0] cfg_thr;

    always @(posedge clk) ncyc <= ncyc + 1;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic beats(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                   input logic mn);
        return mn ? ($signed(a) < $signed(b)) : ($signed(a) > $signed(b));
    endfunction

    function automatic exp_t model();
        exp_t e;
        logic have;
        have    = 1'b0;
        e.value = '0;
        e.addr  = '0;
        e.idx   = '0;
        e.bin   = '0;
        e.found = 1'b0;
        e.cyc   = 0;
        for (int i = 0; i < BIN_LEN; i++) begin
            if (i >= int'(cfg_ws) && i <= int'(cfg_we)) begin
                if (!have || beats(bin_data[i], e.value, cfg_min)) begin
                    have    = 1'b1;
                    e.value = bin_data[i];
                    e.addr  = bin_addr[i];
                    e.idx   = IDX_W'(i);
                end
            end
        end
        e.found = have && beats(e.value, cfg_thr, cfg_min);
        return e;
    endfunction

    task automatic fill_addr(input int base);
        for (int i = 0; i < BIN_LEN; i++) bin_addr[i] = ADDR_W'(base + 3 * i);
    endtask

    task automatic start_shot(input logic mn, input logic [IDX_W-1:0] ws,
                              input logic [IDX_W-1:0] we, input logic [DATA_W-1:0] thr);
        @(posedge clk); #1;
        mode_min  = mn;  cfg_min = mn;
        win_start = ws;  cfg_ws  = ws;
        win_end   = we;  cfg_we  = we;
        threshold = thr; cfg_thr = thr;
        pd_enable = 1'b1;
        exp_bin   = 0;
    endtask

    // Drives nsamp samples of bin_data; only a complete bin produces an expected result.
    task automatic drive_bin(input int nsamp, input int gap_pct);
        exp_t e;
        e = model();
        for (int i = 0; i < nsamp; ) begin
            @(posedge clk); #1;
            if (int'($urandom_range(99)) < gap_pct) begin
                s_valid = 1'b0;
            end else begin
                s_valid = 1'b1;
                s_data  = bin_data[i];
                s_addr  = bin_addr[i];
                if (i == BIN_LEN - 1) begin
                    e.cyc = ncyc + 1;
                    e.bin = BIN_W'(exp_bin);
                    exp_q.push_back(e);
                    exp_bin = (exp_bin + 1) % NUM_BINS;
                end
                i++;
            end
        end
    endtask

    task automatic end_shot();
        @(posedge clk); #1;
        s_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 pd_enable = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk("idle_after_shot", busy, 0);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && pk_valid) begin
            if (exp_q.size() == 0) begin
                chk("spurious_strobe", pk_valid, 0);
            end else begin
                e = exp_q.pop_front();
                chk("pk_value",   pk_value, e.value);
                chk("pk_addr",    pk_addr,  e.addr);
                chk("pk_idx",     pk_idx,   e.idx);
                chk("pk_bin",     pk_bin,   e.bin);
                chk("pk_found",   pk_found, e.found);
                chk("pk_latency", ncyc,     e.cyc);
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, pk_valid, 0);
        chk({tag, "_value"}, pk_value, 0);
        chk({tag, "_addr"},  pk_addr,  0);
        chk({tag, "_idx"},   pk_idx,   0);
        chk({tag, "_bin"},   pk_bin,   0);
        chk({tag, "_found"}, pk_found, 0);
        chk({tag, "_busy"},  busy,     0);
    endtask

    initial begin
        #1 chk_all_zero("reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1 chk_all_zero("post_reset");

        // Ramp, upper half window, max.
        for (int i = 0; i < BIN_LEN; i++) bin_data[i] = DATA_W'(i);
        fill_addr(100);
        start_shot(1'b0, 10'd512, 10'd1023, 32'd0);
        drive_bin(BIN_LEN, 0);
        end_shot();

        // All-negative data: the candidate must not start from zero.
        for (int i = 0; i < BIN_LEN; i++) bin_data[i] = DATA_W'(-1000 - (i % 50));
        bin_data[600] = DATA_W'(-5);
        fill_addr(7);
        start_shot(1'b0, 10'd0, 10'd1023, DATA_W'(-10));
        drive_bin(BIN_LEN, 10);
        end_shot();

        // Tied maxima keep the earliest; a larger value outside the window is ignored.
        for (int i = 0; i < BIN_LEN; i++) bin_data[i] = 32'd10;
        bin_data[100] = 32'd200;
        bin_data[520] = 32'd77;
        bin_data[900] = 32'd77;
        fill_addr(2000);
        start_shot(1'b0, 10'd512, 10'd1000, 32'd50);
        drive_bin(BIN_LEN, 0);
        end_shot();

        // Min search with a tie at 700 and 950.
        for (int i = 0; i < BIN_LEN; i++) bin_data[i] = DATA_W'(1000 + (i * 7) % 500);
        bin_data[700] = 32'd3;
        bin_data[950] = 32'd3;
        fill_addr(5000);
        start_shot(1'b1, 10'd0, 10'd1023, 32'd5);
        drive_bin(BIN_LEN, 0);
        end_shot();

        // Three bins with random gaps; bin number wraps after 1.
        start_shot(1'b0, IDX_W'($urandom_range(0, 500)), IDX_W'($urandom_range(500, 1023)),
                   DATA_W'($urandom));
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < BIN_LEN; i++) bin_data[i] = DATA_W'($urandom);
            fill_addr(b * 1111);
            drive_bin(BIN_LEN, 30);
        end
        end_shot();

        // Abort mid-bin, then the next result restarts at bin 0.
        for (int i = 0; i < BIN_LEN; i++) bin_data[i] = DATA_W'($urandom_range(0, 100000));
        fill_addr(300);
        start_shot(1'b0, 10'd0, 10'd1023, 32'd0);
        drive_bin(BIN_LEN, 20);
        drive_bin(401, 0);
        @(posedge clk); #1;
        s_valid   = 1'b0;
        pd_enable = 1'b0;
        @(posedge clk); #1 chk("abort_busy", busy, 0);
        exp_bin = 0;
        @(posedge clk); #1 pd_enable = 1'b1;
        drive_bin(BIN_LEN, 0);
        end_shot();

        // Inverted window: no candidate, strobe still issued.
        for (int i = 0; i < BIN_LEN; i++) bin_data[i] = DATA_W'(i + 5);
        fill_addr(40);
        start_shot(1'b0, 10'd800, 10'd100, 32'd0);
        drive_bin(BIN_LEN, 0);
        end_shot();

        // Reset in the middle of a bin after non-zero results on bin 1.
        for (int i = 0; i < BIN_LEN; i++) bin_data[i] = DATA_W'(i + 9);
        fill_addr(77);
        start_shot(1'b0, 10'd0, 10'd1023, 32'd0);
        drive_bin(BIN_LEN, 0);
        drive_bin(BIN_LEN, 0);
        drive_bin(300, 0);
        @(posedge clk); #3;
        rst_n     = 1'b0;
        s_valid   = 1'b0;
        pd_enable = 1'b0;
        #1 chk_all_zero("mid_bin_reset");
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);

        #1 chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
